seq_addsub_signed: RTL and testbench
====================================

Name: seq_addsub_signed

Overview:
Parametrised multi-cycle two's-complement adder/subtractor; the next generation of the calculator's 2-bit ripple adder. Processes DIGIT bits per clock, LSB digit first, with one registered carry between digits. Used by the calculator datapath for signed add/sub at any WIDTH, with start/busy/done handshake and status flags.

Parameters:
WIDTH, 3, operand and result width in bits (signed two's complement); WIDTH >= 2
DIGIT, 1, bits processed per RUN cycle; WIDTH % DIGIT == 0 (else elaboration error)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  request new operation; sampled only when accepted (see below)
SUB  in  1  0 = A+B, 1 = A-B; sampled with START
A  in  WIDTH  operand A, sampled with START
B  in  WIDTH  operand B, sampled with START
BUSY  out  1  operation in progress
DONE  out  1  one-cycle pulse: results just updated
Sum  out  WIDTH  result, two's complement
Cout  out  1  carry out of MSB (for SUB: 1 = no borrow, A >= B unsigned)
Overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
Zero  out  1  Sum == 0

Behaviour:
- Reset (RST_N low, async): state IDLE; BUSY=0, DONE=0, Sum=0, Cout=0, Overflow=0, Zero=0; internal operand/carry/step counter cleared. Reset mid-RUN aborts; no DONE is produced, outputs read 0.
- STEPS = WIDTH/DIGIT. Step counter width = clog2(STEPS), min 1.
- States: IDLE, RUN, FIN.
- IDLE: START=1 at edge k -> latch A, B XOR {WIDTH{SUB}}, carry=SUB, step=0; go RUN.
- RUN: each edge adds the current DIGIT-bit slice of both operands plus carry; writes slice into working result register, updates carry; on step STEPS-1 also captures carry into MSB position for overflow; step increments. After STEPS edges (edge k+STEPS) go FIN and copy working result + flags into output registers in that same edge.
- FIN: lasts one cycle; DONE=1. START=1 in FIN is accepted exactly as in IDLE (back-to-back, issue interval STEPS+1 cycles); otherwise -> IDLE.
- BUSY=1 exactly in RUN (STEPS cycles). START while BUSY is ignored, operands not resampled.
- Sum/Cout/Overflow/Zero change only at the FIN-entry edge; hold previous result throughout RUN and IDLE.
- Arithmetic: Sum = (A + (SUB ? ~B : B) + SUB) mod 2^WIDTH; Cout = bit WIDTH of that sum; Overflow = c[WIDTH-1] XOR c[WIDTH]; Zero = ~|Sum.
- DIGIT == WIDTH: STEPS=1, single RUN cycle, latency still 2 edges from START to DONE.
- Latency: START at edge k -> DONE high in cycle after edge k+STEPS.

Test Plan:
WIDTH=3,DIGIT=1: A=011,B=010,SUB=0 -> BUSY 3 cycles, DONE pulse, Sum=101, Cout=0, Overflow=1, Zero=0.
WIDTH=3,DIGIT=1: A=001,B=011,SUB=1 -> Sum=110 (-2), Cout=0, Overflow=0; A=100,B=001,SUB=1 -> Sum=011, Cout=1, Overflow=1.
WIDTH=3: A=010,B=010,SUB=1 -> Sum=000, Zero=1, Cout=1, Overflow=0; START toggled during RUN ignored, A/B changes during RUN do not affect result.
WIDTH=8,DIGIT=4: A=0x7F,B=0x01,SUB=0 -> BUSY 2 cycles, Sum=0x80, Overflow=1, Cout=0; back-to-back START in FIN gives DONE every 3 cycles.
Reset mid-RUN (WIDTH=3, after 1 step): all outputs 0, BUSY=0, no DONE; next START completes normally.
Random WIDTH in {3,8,16}, DIGIT divisors: 1000 ops vs reference model, Sum/flags exact.

Source files
------------

// File: rtl/seq_addsub_signed.sv
// seq_addsub_signed: multi-cycle two's-complement add/sub, DIGIT bits per cycle, LSB digit first
module seq_addsub_signed #(
    parameter int WIDTH = 3,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
        $error("seq_addsub_signed: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, work, work_nx;
    logic             carry, last, cin_msb;
    logic [SW-1:0]    step;
    logic [DIGIT-1:0] sa, sb, ds;
    logic             dc;
    int               idx;

    // one digit slice of the ripple: operands, carry in, and the next working result
    always_comb begin
        idx = int'(step) * DIGIT;
        sa = op_a[idx +: DIGIT];
        sb = op_b[idx +: DIGIT];
        {dc, ds} = {1'b0, sa} + {1'b0, sb} + {{DIGIT{1'b0}}, carry};
        cin_msb = ds[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
        last = step == SW'(STEPS - 1);
        work_nx = work;
        work_nx[idx +: DIGIT] = ds;
    end

    // control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    work  <= work_nx;
                    carry <= dc;
                    step  <= step + 1'b1;
                    if (last) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= work_nx;
                        cout     <= dc;
                        overflow <= cin_msb ^ dc;
                        zero     <= ~|work_nx;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_addsub_signed.sv
// tb_seq_addsub_signed: several parameterisations driven with directed and random ops vs an arithmetic model
module tb_seq_addsub_signed;
    localparam int NI = 6;
    localparam int WS [NI] = '{3, 3, 8, 8, 16, 16};
    localparam int DS [NI] = '{1, 3, 4, 1, 4, 2};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sub;
    logic [15:0]   a, b;
    logic [NI-1:0] start;
    logic [15:0]   sum_o [NI];
    logic          busy_o [NI];
    logic          done_o [NI];
    logic          cout_o [NI];
    logic          ovf_o [NI];
    logic          zero_o [NI];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W-1:0] s;
        seq_addsub_signed #(.WIDTH(W), .DIGIT(DS[g])) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .sub(sub),
            .a(a[W-1:0]), .b(b[W-1:0]),
            .busy(busy_o[g]), .done(done_o[g]), .sum(s),
            .cout(cout_o[g]), .overflow(ovf_o[g]), .zero(zero_o[g])
        );
        assign sum_o[g] = 16'(s);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input int i, input string tag, input int es, input int ec, input int eo, input int ez);
        chk($sformatf("%s sum[%0d]", tag, i), 32'(sum_o[i]), es);
        chk($sformatf("%s cout[%0d]", tag, i), 32'(cout_o[i]), ec);
        chk($sformatf("%s ovf[%0d]", tag, i), 32'(ovf_o[i]), eo);
        chk($sformatf("%s zero[%0d]", tag, i), 32'(zero_o[i]), ez);
    endtask

    // reference: modular sum for Sum/Cout, true signed result range for Overflow
    task automatic model(input int i, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         output int es, output int ec, output int eo, output int ez);
        int w = WS[i];
        longint mask = (64'd1 << w) - 1;
        longint full = (longint'(av) & mask) + ((sv ? ~longint'(bv) : longint'(bv)) & mask) + longint'(sv);
        longint sa = longint'(av) & mask;
        longint sb = longint'(bv) & mask;
        longint r;
        if (sa >= (64'sd1 << (w - 1))) sa -= (64'sd1 << w);
        if (sb >= (64'sd1 << (w - 1))) sb -= (64'sd1 << w);
        r = sv ? sa - sb : sa + sb;
        es = int'(full & mask);
        ec = int'((full >> w) & 1);
        eo = (r < -(64'sd1 << (w - 1)) || r > (64'sd1 << (w - 1)) - 1) ? 1 : 0;
        ez = (es == 0) ? 1 : 0;
    endtask

    // one full operation; inputs and START are scrambled while BUSY to prove they are ignored
    task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv, input logic sv);
        int es, ec, eo, ez, n;
        int st = WS[i] / DS[i];
        model(i, av, bv, sv, es, ec, eo, ez);
        a = av; b = bv; sub = sv; start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        n = 0;
        while (busy_o[i] === 1'b1 && n < 40) begin
            n++;
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); start[i] = 1'($urandom);
            @(posedge clk); #1;
        end
        start[i] = 1'b0;
        chk($sformatf("busy_len[%0d]", i), n, st);
        chk($sformatf("done[%0d]", i), 32'(done_o[i]), 1);
        chk_out(i, "op", es, ec, eo, ez);
        @(posedge clk); #1;
        chk($sformatf("done_drop[%0d]", i), 32'(done_o[i]), 0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = '0; a = '0; b = '0; sub = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst busy[%0d]", i), 32'(busy_o[i]), 0);
            chk($sformatf("rst done[%0d]", i), 32'(done_o[i]), 0);
            chk_out(i, "rst", 0, 0, 0, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(0, 16'h3, 16'h2, 1'b0);
        chk_out(0, "t1", 5, 0, 1, 0);
        run_op(0, 16'h1, 16'h3, 1'b1);
        chk_out(0, "t2a", 6, 0, 0, 0);
        run_op(0, 16'h4, 16'h1, 1'b1);
        chk_out(0, "t2b", 3, 1, 1, 0);
        run_op(0, 16'h2, 16'h2, 1'b1);
        chk_out(0, "t3", 0, 1, 0, 1);
        run_op(1, 16'h3, 16'h2, 1'b0);
        chk_out(1, "full_digit", 5, 0, 1, 0);
        run_op(2, 16'h7f, 16'h01, 1'b0);
        chk_out(2, "t4", 8'h80, 0, 1, 0);

        // START held high: accepted again in every FIN, DONE every STEPS+1 cycles
        a = 16'h7f; b = 16'h01; sub = 1'b0; start[2] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b done c%0d", c), 32'(done_o[2]), (c % 3 == 2) ? 1 : 0);
        end
        start[2] = 1'b0;
        chk_out(2, "b2b", 8'h80, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset after one RUN step aborts the operation
        a = 16'h3; b = 16'h2; sub = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy_o[0]), 0);
        chk("abort done", 32'(done_o[0]), 0);
        chk_out(0, "abort", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= done_o[0];
        end
        chk("abort no_done", 32'(seen), 0);
        run_op(0, 16'h1, 16'h1, 1'b0);
        chk_out(0, "after_abort", 2, 0, 0, 0);

        for (int k = 0; k < 1000; k++)
            run_op(int'($urandom_range(NI - 1, 0)), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
